// File: rtl/bit_sync_edge.sv
// bit_sync_edge: per-channel flop-chain synchroniser followed by a stability
// filter and registered rise/fall pulses on the filtered level.
// Channels are independent single bits; never use this for multi-bit buses.
module bit_sync_edge #(
  parameter int                   Num_Stages  = 2,
  parameter int                   Bus_Width   = 1,
  parameter int                   Filter_Len  = 1,
  parameter logic [Bus_Width-1:0] Reset_Value = {Bus_Width{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [Bus_Width-1:0] Async_Bits,
  output logic [Bus_Width-1:0] Sync_Bits,
  output logic [Bus_Width-1:0] Filt_Bits,
  output logic [Bus_Width-1:0] Rise_Pulse,
  output logic [Bus_Width-1:0] Fall_Pulse
);

  // Counter only has to reach Filter_Len-1; keep at least one bit.
  localparam int              CntW   = (Filter_Len > 1) ? $clog2(Filter_Len) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Filter_Len - 1);

  if (Num_Stages < 2) begin : g_bad_stages
    $error("bit_sync_edge: Num_Stages must be at least 2");
  end
  if (Filter_Len < 1) begin : g_bad_filter
    $error("bit_sync_edge: Filter_Len must be at least 1");
  end

  logic [Bus_Width-1:0] chain_q [Num_Stages];
  logic [Bus_Width-1:0] chain_d [Num_Stages];
  logic [Bus_Width-1:0] sync_s;
  logic [Bus_Width-1:0] filt_q, filt_d;
  logic [Bus_Width-1:0] rise_q, rise_d;
  logic [Bus_Width-1:0] fall_q, fall_d;
  logic [CntW-1:0]      cnt_q [Bus_Width];
  logic [CntW-1:0]      cnt_d [Bus_Width];

  // The last chain stage is the synchronised level; no extra output flop.
  assign sync_s = chain_q[Num_Stages-1];

  // Next state of the synchroniser chain: stage 0 samples the pin, stage k samples stage k-1.
  always_comb begin
    chain_d[0] = Async_Bits;
    for (int k = 1; k < Num_Stages; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  // Stability filter: accept a new level only after it differs for Filter_Len consecutive samples.
  always_comb begin
    filt_d = filt_q;
    rise_d = {Bus_Width{1'b0}};
    fall_d = {Bus_Width{1'b0}};
    for (int i = 0; i < Bus_Width; i++) begin
      cnt_d[i] = {CntW{1'b0}};
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = {CntW{1'b0}};
      end else if (cnt_q[i] == CntMax) begin
        // Pulse is registered together with the new level, so it marks its first cycle.
        filt_d[i] = sync_s[i];
        rise_d[i] = sync_s[i];
        fall_d[i] = ~sync_s[i];
        cnt_d[i]  = {CntW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // State registers; reset is asynchronous so outputs clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Num_Stages; k++) begin
        chain_q[k] <= Reset_Value;
      end
      for (int i = 0; i < Bus_Width; i++) begin
        cnt_q[i] <= {CntW{1'b0}};
      end
      filt_q <= Reset_Value;
      rise_q <= {Bus_Width{1'b0}};
      fall_q <= {Bus_Width{1'b0}};
    end else begin
      for (int k = 0; k < Num_Stages; k++) begin
        chain_q[k] <= chain_d[k];
      end
      for (int i = 0; i < Bus_Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign Sync_Bits  = sync_s;
  assign Filt_Bits  = filt_q;
  assign Rise_Pulse = rise_q;
  assign Fall_Pulse = fall_q;

endmodule

// File: tb/tb_bit_sync_edge.sv
// Bench for bit_sync_edge: eleven instances with different depth/filter
// settings share one stimulus. Each instance has a window-based reference
// model feeding a scoreboard queue and a monitor popping it every cycle;
// directed checks cover reset, latency, glitch, independence and reset
// in the middle of filtering.
module tb_bit_sync_edge;

  localparam int         NCfg = 11;
  localparam int         BW   = 4;
  localparam logic [3:0] RV   = 4'b1010;

  typedef struct packed {
    logic [3:0] sync;
    logic [3:0] filt;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [3:0] async_bits = RV;

  logic [3:0] sync_a [NCfg];
  logic [3:0] filt_a [NCfg];
  logic [3:0] rise_a [NCfg];
  logic [3:0] fall_a [NCfg];

  int total = 0;
  int bad   = 0;

  initial forever #5 clk = ~clk;

  // Configs 0..8 sweep Num_Stages {2,3,4} x Filter_Len {1,2,5};
  // config 9 is NS=2/FL=3, config 10 is NS=2/FL=4 for directed checks.
  for (genvar g = 0; g < NCfg; g++) begin : g_cfg
    localparam int NS = (g < 9) ? 2 + g / 3 : 2;
    localparam int FL = (g == 9) ? 3 : (g == 10) ? 4 :
                        ((g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 5);

    exp_t exp_q [$];

    bit_sync_edge #(
      .Num_Stages (NS),
      .Bus_Width  (BW),
      .Filter_Len (FL),
      .Reset_Value(RV)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Async_Bits(async_bits),
      .Sync_Bits (sync_a[g]),
      .Filt_Bits (filt_a[g]),
      .Rise_Pulse(rise_a[g]),
      .Fall_Pulse(fall_a[g])
    );

    // Reference model: samp holds every input sample since reset, shist[k]
    // is the synchronised value present after edge k (shist[0] = reset value).
    // A filtered bit flips at edge n when the FL most recent synchronised
    // values before that edge all differ from it.
    initial begin : model
      logic [3:0] samp [$];
      logic [3:0] shist [$];
      logic [3:0] filt, rise, fall, s_now;
      exp_t       e;
      int         n;
      bit         all_diff;
      n = 0;
      filt = RV;
      shist.push_back(RV);
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          samp.delete();
          shist.delete();
          shist.push_back(RV);
          n = 0;
          filt = RV;
          e.sync = RV; e.filt = RV; e.rise = 4'b0000; e.fall = 4'b0000;
          exp_q.delete();
          exp_q.push_back(e);
        end else begin
          n++;
          samp.push_back(async_bits);
          rise = 4'b0000;
          fall = 4'b0000;
          for (int i = 0; i < BW; i++) begin
            all_diff = (n >= FL);
            for (int k = n - FL; k < n && all_diff; k++) begin
              if (shist[k][i] == filt[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
              rise[i] = ~filt[i];
              fall[i] = filt[i];
              filt[i] = ~filt[i];
            end
          end
          s_now = (n >= NS) ? samp[n-NS] : RV;
          shist.push_back(s_now);
          e.sync = s_now; e.filt = filt; e.rise = rise; e.fall = fall;
          exp_q.push_back(e);
        end
      end
    end

    // Monitor: one DUT output set per cycle, compared on the falling edge.
    initial begin : monitor
      exp_t e;
      @(posedge clk);
      forever begin
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty cfg=%0d t=%0t", g, $time);
        end else begin
          e = exp_q.pop_front();
          if ({sync_a[g], filt_a[g], rise_a[g], fall_a[g]} !== e) begin
            bad++;
            $display("FAIL sb cfg=%0d t=%0t got sync=%b filt=%b rise=%b fall=%b want sync=%b filt=%b rise=%b fall=%b",
                     g, $time, sync_a[g], filt_a[g], rise_a[g], fall_a[g],
                     e.sync, e.filt, e.rise, e.fall);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int hi;
    // Reset held low: outputs at reset value, no pulses.
    async_bits = RV;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sync", sync_a[9], RV);
    chk("rst_filt", filt_a[9], RV);
    chk("rst_pulse", rise_a[9] | fall_a[9], 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_edge();
      chk("rel_sync", sync_a[9], RV);
      chk("rel_filt", filt_a[9], RV);
      chk("rel_pulse", rise_a[9] | fall_a[9], 4'b0000);
    end

    // Rising edge latency on bit 0 (NS=2, FL=3 and FL=4).
    #1 async_bits = 4'b1011;
    for (int e = 1; e <= 7; e++) begin
      next_edge();
      chk("lat_sync", sync_a[9], (e >= 2) ? 4'b1011 : 4'b1010);
      chk("lat_filt", filt_a[9], (e >= 5) ? 4'b1011 : 4'b1010);
      chk("lat_rise", rise_a[9], (e == 5) ? 4'b0001 : 4'b0000);
      chk("lat_rise_fl4", rise_a[10], (e == 6) ? 4'b0001 : 4'b0000);
    end

    // Glitch rejection on bit 1: drop it, settle, then pulse it for 2 sampling edges.
    #1 async_bits = 4'b1001;
    repeat (12) next_edge();
    #1 async_bits = 4'b1011;
    hi = 0;
    for (int c = 0; c < 12; c++) begin
      next_edge();
      if (sync_a[9][1]) hi++;
      chk("glitch_filt", filt_a[9], 4'b1001);
      chk("glitch_pulse", rise_a[9] | fall_a[9], 4'b0000);
      if (c == 1) #1 async_bits = 4'b1001;
    end
    total++;
    if (hi != 2) begin
      bad++;
      $display("FAIL glitch_sync_cycles got=%0d want=2", hi);
    end

    // Simultaneous fall on bit 2 and rise on bit 3.
    #1 async_bits = 4'b0101;
    repeat (12) next_edge();
    #1 async_bits = 4'b1001;
    for (int e = 1; e <= 6; e++) begin
      next_edge();
      chk("indep_filt", filt_a[9], (e >= 5) ? 4'b1001 : 4'b0101);
      chk("indep_rise", rise_a[9], (e == 5) ? 4'b1000 : 4'b0000);
      chk("indep_fall", fall_a[9], (e == 5) ? 4'b0100 : 4'b0000);
    end

    // Reset while bit 0 of the FL=4 instance has counted to 2.
    #1 async_bits = 4'b0000;
    repeat (14) next_edge();
    #1 async_bits = 4'b0001;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sync", sync_a[10], RV);
    chk("midrst_filt", filt_a[10], RV);
    chk("midrst_pulse", rise_a[10] | fall_a[10], 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      next_edge();
      chk("midrst_rel_filt", filt_a[10], (e >= 6) ? 4'b0001 : 4'b1010);
      chk("midrst_rel_rise", rise_a[10], (e == 6) ? 4'b0001 : 4'b0000);
      chk("midrst_rel_fall", fall_a[10], (e == 6) ? 4'b1010 : 4'b0000);
    end

    // Random phase with a fast-toggle window and a mid-run reset; scoreboards check it all.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      if (c >= 200 && c < 240) begin
        async_bits = ~async_bits;
      end else if ($urandom_range(0, 3) == 0) begin
        async_bits = 4'($urandom);
      end
      if (c == 700) rst_n = 1'b0;
      if (c == 703) rst_n = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_sync_edge.md
# bit_sync_edge

Parametrised multi-channel synchroniser for asynchronous single-bit inputs such as buttons, status lines and handshake flags. Each channel passes through a Num_Stages flop chain, then a per-channel stability filter. The block provides the synchronised level, the filtered level, and single-cycle rise and fall pulses per channel. It replaces hand-instantiated bit synchronisers plus ad-hoc edge detectors at the receiving clock domain boundary.

## Interface
- Num_Stages, 2: synchroniser depth per channel; legal range ≥ 2.
- Bus_Width, 1: number of independent channels; legal range ≥ 1.
- Filter_Len, 1: consecutive cycles a new synchronised value must hold before the filtered level accepts it; legal range ≥ 1.
- Reset_Value, {Bus_Width{1'b0}}: per-channel reset level for every chain stage and for Filt_Bits.
- clk  input  1  sole clock; every register is on its rising edge.
- rst_n  input  1  reset, asynchronous assert and active-low; one clock domain.
- Async_Bits  input  Bus_Width  asynchronous inputs, one per channel.
- Sync_Bits  output  Bus_Width  last chain stage per channel.
- Filt_Bits  output  Bus_Width  filtered (debounced) level per channel.
- Rise_Pulse  output  Bus_Width  one-cycle pulse on a 0→1 change of Filt_Bits[i].
- Fall_Pulse  output  Bus_Width  one-cycle pulse on a 1→0 change of Filt_Bits[i].

## Operation
- Illegal parameters: Num_Stages < 2 or Filter_Len < 1 is an elaboration-time error.
- Channels are fully independent; there is no cross-channel coherency. The block does not carry multi-bit buses.
- Chain: stage 0 samples Async_Bits[i]; stage k samples stage k-1. Sync_Bits[i] is stage Num_Stages-1, with no extra output register.
- Filter state per channel:
  - Filt_Bits[i] (register).
  - Counter cnt[i], width max(1, $clog2(Filter_Len)).
- Filter rules, evaluated each edge:
  - Sync_Bits[i] == Filt_Bits[i]: cnt ← 0.
  - Differ and cnt == Filter_Len-1: Filt_Bits ← Sync_Bits and cnt ← 0.
  - Differ otherwise: cnt ← cnt+1.
  - cnt never exceeds Filter_Len-1 and never wraps.
- Pulses are registered:
  - Rise_Pulse[i] ← 1 at the edge where Filt_Bits[i] is updated 0→1, else 0.
  - Fall_Pulse[i] ← 1 at the edge where Filt_Bits[i] is updated 1→0, else 0.
  - Each pulse is high for exactly the first cycle of the new Filt_Bits level.
  - Rise_Pulse[i] and Fall_Pulse[i] are never high together.
- Reset (rst_n low, any time, including mid-filter):
  - Chain stages and Filt_Bits take Reset_Value.
  - cnt = 0; Rise_Pulse = Fall_Pulse = 0.
  - Outputs change immediately, without waiting for a clock edge.
  - No pulse is generated by reset entry or exit.
- After reset release, if Async_Bits[i] ≠ Reset_Value[i], the change propagates as a normal edge and produces a pulse.

## Timing
- Take edge 1 as the first edge that samples a new stable Async_Bits[i].
  - Sync_Bits[i] changes after edge Num_Stages.
  - Filt_Bits[i] and the matching pulse change after edge Num_Stages+Filter_Len.
  - The pulse drops after edge Num_Stages+Filter_Len+1.
- Total input-to-pulse latency: Num_Stages+Filter_Len edges.
- Glitch rejection: a Sync_Bits[i] excursion shorter than Filter_Len cycles never reaches Filt_Bits and produces no pulse.
- Minimum spacing between successive pulses on one channel: Filter_Len cycles.
- An input toggling every cycle with Filter_Len ≥ 2 produces no filtered change.
- Metastability resolution is a property of the chain only. Downstream logic uses Sync_Bits, Filt_Bits or the pulses, never Async_Bits.

## Test plan
1. **Reset:** Bus_Width=4, Reset_Value=4'b1010. Hold rst_n low, then release with Async_Bits=4'b1010 -> Sync_Bits=Filt_Bits=4'b1010, and no pulse for 20 cycles.
2. **Rising edge latency:** Num_Stages=2, Filter_Len=3. Async_Bits[0] goes 0→1 before edge 1 -> Sync_Bits[0]=1 after edge 2, Filt_Bits[0]=1 and Rise_Pulse[0]=1 after edge 5, Rise_Pulse[0]=0 after edge 6.
3. **Glitch rejection:** Filter_Len=3. Async_Bits[1] high across exactly 2 sampling edges -> Sync_Bits[1] high for 2 cycles, Filt_Bits[1] stays 0, no Rise_Pulse or Fall_Pulse.
4. **Fall and independence:** bit 2 falls 1→0 in the same cycle that bit 3 rises 0→1 -> Fall_Pulse[2] and Rise_Pulse[3] are both high in the same single cycle, and no other bits change.
5. **Reset mid-filter:** Filter_Len=4, cnt[0]=2. Assert rst_n between edges -> Filt_Bits, cnt and pulses clear immediately. After release with the input held high, Rise_Pulse[0] appears exactly Num_Stages+4 edges later.
6. **Depth sweep:** Num_Stages ∈ {2,3,4} × Filter_Len ∈ {1,2,5} with random input -> the scoreboard model matches Sync_Bits, Filt_Bits and both pulses every cycle.
